fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the control decoder.
- Holds the program counter and addresses instruction memory.
- Presents the current 9-bit instruction, with opcode and type-select fields split out, to the decoder.
- Applies absolute branches using the decoder's Branch output and the ALU condition flag; runs a start/done handshake with the testbench.

---
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: program counter, branch apply, start/done handshake
//
// Purpose: holds the program counter, addresses instruction memory and hands the
// current instruction (opcode and type-select fields split out) to the decoder.
// Runs IDLE -> RUN -> DONE under a level start input; HALT ends a program.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   start        level; begin execution at prog_base (ignored while running)
//   prog_base    first instruction address of the program
//   branch       decoder Branch for the current instruction
//   cond         ALU branch condition for the current instruction (1 = take)
//   target       absolute branch target
//   imem_addr    instruction memory address (= pc)
//   imem_data    instruction memory read data (combinational)
//   instr        instruction presented downstream (NOP outside RUN)
//   instr_op     instr[8:6]
//   instr_type   instr[2:0]
//   running      high while in RUN
//   done         high while in DONE
//   cycle_count  RUN cycles in the current or most recent program (saturating)
module fetch_unit #(
  parameter int PCW  = 10,
  parameter int IW   = 9,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [PCW-1:0]  prog_base,
  input  logic            branch,
  input  logic            cond,
  input  logic [PCW-1:0]  target,
  output logic [PCW-1:0]  imem_addr,
  input  logic [IW-1:0]   imem_data,
  output logic [IW-1:0]   instr,
  output logic [2:0]      instr_op,
  output logic [2:0]      instr_type,
  output logic            running,
  output logic            done,
  output logic [CNTW-1:0] cycle_count
);

  localparam logic [IW-1:0] NOP  = IW'(9'b111_000_000);
  localparam logic [IW-1:0] HALT = IW'(9'b111_111_111);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            is_halt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign is_halt = (imem_data == HALT);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = prog_base;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // HALT cycle still counts; saturate rather than wrap the counter
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNTW'(1);
        if (is_halt) begin
          state_d = DONE;
        end else if (branch && cond) begin
          pc_d = target;
        end else begin
          pc_d = pc_q + PCW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOP outside RUN keeps the decoder from writing registers or memory
  assign instr       = (state_q == RUN) ? imem_data : NOP;
  assign instr_op    = instr[IW-1:IW-3];
  assign instr_type  = instr[2:0];
  assign imem_addr   = pc_q;
  assign running     = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [8:0] NOP  = 9'h1C0;
  localparam logic [8:0] HALT = 9'h1FF;
  localparam logic [8:0] FILL = 9'h041;

  logic       clk;
  logic       reset;
  logic       start;
  logic [9:0] prog_base;
  logic       branch;
  logic       cond;
  logic [9:0] target;

  logic [9:0]  imem_addr;
  logic [8:0]  imem_data;
  logic [8:0]  instr;
  logic [2:0]  instr_op;
  logic [2:0]  instr_type;
  logic        running;
  logic        done;
  logic [15:0] cycle_count;

  logic [9:0] s_addr;
  logic [8:0] s_data;
  logic [8:0] s_instr;
  logic [2:0] s_op;
  logic [2:0] s_type;
  logic       s_running;
  logic       s_done;
  logic [3:0] s_count;

  logic [8:0] mem [0:1023];

  int checks;
  int errors;

  assign imem_data = mem[imem_addr];
  assign s_data    = mem[s_addr];

  fetch_unit #(.PCW(10), .IW(9), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_base(prog_base),
    .branch(branch), .cond(cond), .target(target),
    .imem_addr(imem_addr), .imem_data(imem_data), .instr(instr),
    .instr_op(instr_op), .instr_type(instr_type),
    .running(running), .done(done), .cycle_count(cycle_count)
  );

  fetch_unit #(.PCW(10), .IW(9), .CNTW(4)) sat_dut (
    .clk(clk), .reset(reset), .start(start), .prog_base(prog_base),
    .branch(branch), .cond(cond), .target(target),
    .imem_addr(s_addr), .imem_data(s_data), .instr(s_instr),
    .instr_op(s_op), .instr_type(s_type),
    .running(s_running), .done(s_done), .cycle_count(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; prog_base = '0;
    branch = 1'b0; cond = 1'b0; target = '0;
    step();
    step();
    checks++;
    if ({imem_addr, running, done, cycle_count} !== {10'd0, 1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL reset_state: pc/run/done/cnt = %0d/%b/%b/%0d, want 0/0/0/0", imem_addr, running, done, cycle_count);
    end
    checks++;
    if ({instr, instr_op, instr_type} !== {NOP, 3'd7, 3'd0}) begin
      errors++;
      $display("FAIL reset_instr: instr/op/type = %h/%0d/%0d, want 1c0/7/0", instr, instr_op, instr_type);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({running, done, imem_addr} !== {1'b0, 1'b0, 10'd0}) begin
      errors++;
      $display("FAIL idle_hold: run/done/pc = %b/%b/%0d, want 0/0/0", running, done, imem_addr);
    end
  endtask

  task automatic test_sequential();
    mem[10] = 9'b101_010_011;
    mem[13] = HALT;
    start = 1'b1; prog_base = 10'd10;
    step();
    start = 1'b0;
    checks++;
    if ({imem_addr, running, cycle_count} !== {10'd10, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL seq_start: pc/run/cnt = %0d/%b/%0d, want 10/1/0", imem_addr, running, cycle_count);
    end
    checks++;
    if ({instr, instr_op, instr_type} !== {9'b101_010_011, 3'd5, 3'd3}) begin
      errors++;
      $display("FAIL seq_instr: instr/op/type = %h/%0d/%0d, want 153/5/3", instr, instr_op, instr_type);
    end
    for (int i = 11; i <= 13; i++) begin
      step();
      checks++;
      if (imem_addr !== 10'(i) || running !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL seq_pc: pc/run/done = %0d/%b/%b, want %0d/1/0", imem_addr, running, done, i);
      end
    end
    step();
    checks++;
    if ({done, running, imem_addr, cycle_count, instr} !== {1'b1, 1'b0, 10'd13, 16'd4, NOP}) begin
      errors++;
      $display("FAIL seq_done: done/run/pc/cnt/instr = %b/%b/%0d/%0d/%h, want 1/0/13/4/1c0", done, running, imem_addr, cycle_count, instr);
    end
  endtask

  task automatic test_branch();
    mem[7] = HALT;
    start = 1'b1; prog_base = 10'd5;
    step();
    start = 1'b0;
    branch = 1'b1; cond = 1'b1; target = 10'd40;
    step();
    checks++;
    if (imem_addr !== 10'd40) begin
      errors++;
      $display("FAIL branch_taken: pc = %0d, want 40", imem_addr);
    end
    target = 10'd5;
    step();
    cond = 1'b0; target = 10'd40;
    step();
    checks++;
    if (imem_addr !== 10'd6) begin
      errors++;
      $display("FAIL branch_not_taken: pc = %0d, want 6", imem_addr);
    end
    branch = 1'b0; cond = 1'b1;
    step();
    branch = 1'b1; cond = 1'b1; target = 10'd0;
    step();
    checks++;
    if ({done, imem_addr, cycle_count} !== {1'b1, 10'd7, 16'd5}) begin
      errors++;
      $display("FAIL halt_wins: done/pc/cnt = %b/%0d/%0d, want 1/7/5", done, imem_addr, cycle_count);
    end
    branch = 1'b0; cond = 1'b0;
  endtask

  task automatic test_async_reset();
    start = 1'b1; prog_base = 10'd20;
    step();
    start = 1'b0;
    step();
    step();
    checks++;
    if (imem_addr !== 10'd22 || running !== 1'b1) begin
      errors++;
      $display("FAIL pre_abort: pc/run = %0d/%b, want 22/1", imem_addr, running);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({imem_addr, running, done, instr, cycle_count} !== {10'd0, 1'b0, 1'b0, NOP, 16'd0}) begin
      errors++;
      $display("FAIL async_abort: pc/run/done/instr/cnt = %0d/%b/%b/%h/%0d, want 0/0/0/1c0/0", imem_addr, running, done, instr, cycle_count);
    end
    #1 reset = 1'b0;
    step();
    checks++;
    if ({imem_addr, running} !== {10'd0, 1'b0}) begin
      errors++;
      $display("FAIL post_abort_idle: pc/run = %0d/%b, want 0/0", imem_addr, running);
    end
  endtask

  task automatic test_start_held();
    mem[33] = HALT;
    start = 1'b1; prog_base = 10'd30;
    step();
    prog_base = 10'd100;
    for (int i = 31; i <= 33; i++) begin
      step();
      checks++;
      if (imem_addr !== 10'(i) || running !== 1'b1) begin
        errors++;
        $display("FAIL start_ignored: pc/run = %0d/%b, want %0d/1", imem_addr, running, i);
      end
    end
    start = 1'b0;
    step();
    step();
    checks++;
    if ({done, imem_addr, cycle_count} !== {1'b1, 10'd33, 16'd4}) begin
      errors++;
      $display("FAIL done_hold: done/pc/cnt = %b/%0d/%0d, want 1/33/4", done, imem_addr, cycle_count);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({running, done, imem_addr, cycle_count} !== {1'b1, 1'b0, 10'd100, 16'd0}) begin
      errors++;
      $display("FAIL restart: run/done/pc/cnt = %b/%b/%0d/%0d, want 1/0/100/0", running, done, imem_addr, cycle_count);
    end
  endtask

  task automatic test_wrap_and_saturate();
    branch = 1'b1; cond = 1'b1; target = 10'd1023;
    step();
    checks++;
    if (imem_addr !== 10'd1023) begin
      errors++;
      $display("FAIL branch_top: pc = %0d, want 1023", imem_addr);
    end
    branch = 1'b0;
    step();
    checks++;
    if ({imem_addr, running} !== {10'd0, 1'b1}) begin
      errors++;
      $display("FAIL pc_wrap: pc/run = %0d/%b, want 0/1", imem_addr, running);
    end
    branch = 1'b1; cond = 1'b1; target = 10'd0;
    for (int i = 0; i < 20; i++) step();
    checks++;
    if ({imem_addr, cycle_count} !== {10'd0, 16'd22}) begin
      errors++;
      $display("FAIL tight_loop: pc/cnt = %0d/%0d, want 0/22", imem_addr, cycle_count);
    end
    checks++;
    if (s_count !== 4'd15) begin
      errors++;
      $display("FAIL saturate: cnt4 = %0d, want 15", s_count);
    end
    mem[1] = HALT;
    branch = 1'b0; cond = 1'b0;
    step();
    step();
    checks++;
    if ({done, imem_addr, cycle_count} !== {1'b1, 10'd1, 16'd24}) begin
      errors++;
      $display("FAIL final_done: done/pc/cnt = %b/%0d/%0d, want 1/1/24", done, imem_addr, cycle_count);
    end
    checks++;
    if ({s_running, s_done, s_instr, s_op, s_type, s_addr, s_count} !==
        {1'b0, 1'b1, NOP, 3'd7, 3'd0, 10'd1, 4'd15}) begin
      errors++;
      $display("FAIL sat_done: run/done/instr/op/type/pc/cnt = %b/%b/%h/%0d/%0d/%0d/%0d, want 0/1/1c0/7/0/1/15",
               s_running, s_done, s_instr, s_op, s_type, s_addr, s_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = FILL;
    test_reset();
    test_sequential();
    test_branch();
    test_async_reset();
    test_start_held();
    test_wrap_and_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
